// File: rtl/branch_resolve_bht.sv
// ---------------------------------------------------------------------------
// branch_resolve_bht
//
// Branch resolution and dynamic prediction for a single-issue pipeline.
//   * EX side: selects signed/unsigned compare for the branch comparator,
//     decodes the actual taken/not-taken outcome from funct3 and the
//     comparator flags, detects a mispredict and supplies the redirect PC.
//   * Fetch side: a PC-indexed table of 2-bit saturating counters plus a
//     tagged BTB, read combinationally by fetch and trained by EX.
//
// Parameters
//   IDX_W     table index width; ENTRIES = 2**IDX_W, index = pc[IDX_W+1:2]
//   CNT_INIT  counter reset value (2'b01 = weakly not-taken)
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_f_pc           fetch PC used for the lookup
//   o_pred_taken     fetch should redirect to o_pred_target
//   o_pred_target    BTB target of the indexed entry (driven even when not taken)
//   i_ex_valid       EX holds a real instruction this cycle
//   i_ex_is_br       conditional branch (B-type)
//   i_ex_is_jmp      JAL/JALR
//   i_ex_funct3      B-type funct3
//   i_ex_pc          PC of the EX instruction
//   i_ex_target      computed target
//   i_ex_pred_tkn    prediction carried with the instruction
//   i_ex_pred_tgt    predicted target carried with the instruction
//   o_br_unsigned    comparator mode: 1 for BLTU/BGEU
//   i_br_less        comparator: rs1 < rs2
//   i_br_equal       comparator: rs1 == rs2
//   o_ex_taken       actual outcome of the EX instruction
//   o_redirect       mispredict: flush IF/ID and load o_redirect_pc
//   o_redirect_pc    correct next PC
//   o_mispred_cnt    running mispredict count (wraps)
//
// Qualifier semantics: i_ex_valid is a plain per-cycle qualifier with no
// back-pressure. When it is low the EX inputs are ignored for outcome,
// redirect and training; when it is high they are consumed on that cycle's
// rising edge. There is no ready; the unit always accepts.
// ---------------------------------------------------------------------------
module branch_resolve_bht #(
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_f_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_ex_valid,
    input  logic        i_ex_is_br,
    input  logic        i_ex_is_jmp,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_tkn,
    input  logic [31:0] i_ex_pred_tgt,
    output logic        o_br_unsigned,
    input  logic        i_br_less,
    input  logic        i_br_equal,
    output logic        o_ex_taken,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 32 - IDX_W - 2;

    // Table storage
    logic             btb_v   [ENTRIES];
    logic [TAG_W-1:0] btb_tag [ENTRIES];
    logic [31:0]      btb_tgt [ENTRIES];
    logic [1:0]       cnt     [ENTRIES];

    // Fetch lookup
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;

    // EX decode / update
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             br_cond;
    logic             br_legal;
    logic             taken;
    logic             upd_en;
    logic             ex_hit;
    logic [1:0]       cnt_inc;
    logic [1:0]       cnt_dec;

    // Instruction fetch is word aligned, so the two low PC bits carry no
    // information for either the index or the tag.
    logic unused_f_pc_lsb;
    assign unused_f_pc_lsb = ^i_f_pc[1:0];

    // -----------------------------------------------------------------------
    // Fetch-side lookup: reads the registered table, so an update landing on
    // the same index this cycle is seen only from the next cycle on.
    // -----------------------------------------------------------------------
    assign f_idx         = i_f_pc[IDX_W+1:2];
    assign f_tag         = i_f_pc[31:IDX_W+2];
    assign o_pred_taken  = btb_v[f_idx] & (btb_tag[f_idx] == f_tag) & cnt[f_idx][1];
    assign o_pred_target = btb_tgt[f_idx];

    // -----------------------------------------------------------------------
    // EX-side resolution
    // -----------------------------------------------------------------------
    assign o_br_unsigned = i_ex_funct3[1];

    always_comb begin
        br_cond  = 1'b0;
        br_legal = 1'b1;
        unique case (i_ex_funct3)
            3'b000:  br_cond = i_br_equal;   // BEQ
            3'b001:  br_cond = ~i_br_equal;  // BNE
            3'b100:  br_cond = i_br_less;    // BLT
            3'b101:  br_cond = ~i_br_less;   // BGE
            3'b110:  br_cond = i_br_less;    // BLTU
            3'b111:  br_cond = ~i_br_less;   // BGEU
            default: br_legal = 1'b0;        // 010/011: never taken, never trained
        endcase
    end

    // A jump overrides the branch decode even if both flags are set.
    assign taken = i_ex_is_jmp | (i_ex_is_br & br_cond);

    assign o_ex_taken    = i_ex_valid & taken;
    assign o_redirect    = i_ex_valid & (i_ex_is_br | i_ex_is_jmp) &
                           ((taken != i_ex_pred_tkn) |
                            (taken & (i_ex_pred_tgt != i_ex_target)));
    assign o_redirect_pc = taken ? i_ex_target : (i_ex_pc + 32'd4);

    // -----------------------------------------------------------------------
    // Training
    // -----------------------------------------------------------------------
    assign ex_idx  = i_ex_pc[IDX_W+1:2];
    assign ex_tag  = i_ex_pc[31:IDX_W+2];
    assign upd_en  = i_ex_valid & (i_ex_is_jmp | (i_ex_is_br & br_legal));
    assign ex_hit  = btb_v[ex_idx] & (btb_tag[ex_idx] == ex_tag);
    assign cnt_inc = (cnt[ex_idx] == 2'b11) ? 2'b11 : (cnt[ex_idx] + 2'd1);
    assign cnt_dec = (cnt[ex_idx] == 2'b00) ? 2'b00 : (cnt[ex_idx] - 2'd1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_v[i]   <= 1'b0;
                btb_tag[i] <= '0;
                btb_tgt[i] <= '0;
                cnt[i]     <= CNT_INIT;
            end
        end else if (upd_en) begin
            if (i_ex_is_jmp) begin
                // Jumps are always taken: claim the entry at full strength.
                btb_v[ex_idx]   <= 1'b1;
                btb_tag[ex_idx] <= ex_tag;
                btb_tgt[ex_idx] <= i_ex_target;
                cnt[ex_idx]     <= 2'b11;
            end else if (taken) begin
                // A taken branch that misses the tag evicts the previous owner
                // and starts at weakly-taken rather than inheriting its count.
                btb_v[ex_idx]   <= 1'b1;
                btb_tag[ex_idx] <= ex_tag;
                btb_tgt[ex_idx] <= i_ex_target;
                cnt[ex_idx]     <= ex_hit ? cnt_inc : 2'b10;
            end else if (ex_hit) begin
                // Not-taken only weakens an entry this branch owns; another
                // branch's entry is left alone.
                cnt[ex_idx]     <= cnt_dec;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mispred_cnt <= '0;
        end else if (o_redirect) begin
            o_mispred_cnt <= o_mispred_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_bht
//
// Directed bench for branch_resolve_bht. Expected values are pushed into
// exp_q when a step is driven and popped in the same order when the DUT
// outputs are sampled, two time units after the falling edge (well clear
// of the rising edge that commits training).
// ---------------------------------------------------------------------------
module tb_branch_resolve_bht;

    logic        clk;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_br;
    logic        ex_is_jmp;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_tkn;
    logic [31:0] ex_pred_tgt;
    logic        br_unsigned;
    logic        br_less;
    logic        br_equal;
    logic        ex_taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mispred_cnt;

    logic [31:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    branch_resolve_bht #(.IDX_W(4), .CNT_INIT(2'b01)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_f_pc        (f_pc),
        .o_pred_taken  (pred_taken),
        .o_pred_target (pred_target),
        .i_ex_valid    (ex_valid),
        .i_ex_is_br    (ex_is_br),
        .i_ex_is_jmp   (ex_is_jmp),
        .i_ex_funct3   (ex_funct3),
        .i_ex_pc       (ex_pc),
        .i_ex_target   (ex_target),
        .i_ex_pred_tkn (ex_pred_tkn),
        .i_ex_pred_tgt (ex_pred_tgt),
        .o_br_unsigned (br_unsigned),
        .i_br_less     (br_less),
        .i_br_equal    (br_equal),
        .o_ex_taken    (ex_taken),
        .o_redirect    (redirect),
        .o_redirect_pc (redirect_pc),
        .o_mispred_cnt (mispred_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle();
        ex_valid    = 1'b0;
        ex_is_br    = 1'b0;
        ex_is_jmp   = 1'b0;
        ex_funct3   = 3'b000;
        ex_pc       = 32'h0;
        ex_target   = 32'h0;
        ex_pred_tkn = 1'b0;
        ex_pred_tgt = 32'h0;
        br_less     = 1'b0;
        br_equal    = 1'b0;
    endtask

    task automatic drive(input logic v, input logic br, input logic jmp,
                         input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic ptkn,
                         input logic [31:0] ptgt, input logic less,
                         input logic eq);
        ex_valid    = v;
        ex_is_br    = br;
        ex_is_jmp   = jmp;
        ex_funct3   = f3;
        ex_pc       = pc;
        ex_target   = tgt;
        ex_pred_tkn = ptkn;
        ex_pred_tgt = ptgt;
        br_less     = less;
        br_equal    = eq;
    endtask

    // Move to the next falling edge; caller drives, then sample() waits.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic sample();
        #2;
    endtask

    task automatic expect_v(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    // Scoreboard compare: pops the oldest expectation.
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp_v;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v)
            else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_tkn, input logic [31:0] exp_tgt);
        f_pc = pc;
        #1;
        expect_v({31'd0, exp_tkn});
        expect_v(exp_tgt);
        check({tag, "_pred_taken"}, {31'd0, pred_taken});
        check({tag, "_pred_target"}, pred_target);
    endtask

    // Directed sequence
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        f_pc     = 32'h100;
        idle();
        repeat (2) @(posedge clk);
        next_cycle();
        rst_n = 1'b1;
        sample();

        // Reset state
        lookup("rst", 32'h100, 1'b0, 32'h0);
        expect_v(32'd0);
        check("rst_mispred", mispred_cnt);

        // BLTU taken at 0x100, predicted not-taken
        next_cycle();
        f_pc = 32'h100;
        drive(1, 1, 0, 3'b110, 32'h100, 32'h40, 0, 32'h0, 1, 0);
        sample();
        expect_v(32'd1); expect_v(32'd1); expect_v(32'd1); expect_v(32'h40);
        check("bltu_unsigned", {31'd0, br_unsigned});
        check("bltu_taken", {31'd0, ex_taken});
        check("bltu_redirect", {31'd0, redirect});
        check("bltu_redirect_pc", redirect_pc);
        lookup("bltu_same", 32'h100, 1'b0, 32'h0);
        next_cycle();
        idle();
        sample();
        expect_v(32'd1);
        check("bltu_mispred", mispred_cnt);
        lookup("bltu_next", 32'h100, 1'b1, 32'h40);

        // Same-cycle lookup and update on one index (target change)
        next_cycle();
        drive(1, 1, 0, 3'b000, 32'h100, 32'h80, 1, 32'h40, 0, 1);
        sample();
        expect_v(32'd1); expect_v(32'h80);
        check("sim_redirect", {31'd0, redirect});
        check("sim_redirect_pc", redirect_pc);
        lookup("sim_same", 32'h100, 1'b1, 32'h40);
        next_cycle();
        idle();
        sample();
        lookup("sim_next", 32'h100, 1'b1, 32'h80);
        expect_v(32'd2);
        check("sim_mispred", mispred_cnt);

        // Jump at 0x200 (same index, new tag) claims the entry
        next_cycle();
        drive(1, 0, 1, 3'b000, 32'h200, 32'h500, 0, 32'h0, 0, 0);
        sample();
        expect_v(32'd1); expect_v(32'd1); expect_v(32'h500);
        check("jal_taken", {31'd0, ex_taken});
        check("jal_redirect", {31'd0, redirect});
        check("jal_redirect_pc", redirect_pc);
        next_cycle();
        idle();
        sample();
        lookup("jal_hit", 32'h200, 1'b1, 32'h500);
        lookup("jal_old_tag", 32'h100, 1'b0, 32'h500);

        // BNE with equal=1, predicted taken: 11 -> 10, still predicts taken
        next_cycle();
        drive(1, 1, 0, 3'b001, 32'h200, 32'h600, 1, 32'h500, 0, 1);
        sample();
        expect_v(32'd0); expect_v(32'd0); expect_v(32'd1); expect_v(32'h204);
        check("bne_unsigned", {31'd0, br_unsigned});
        check("bne_taken", {31'd0, ex_taken});
        check("bne_redirect", {31'd0, redirect});
        check("bne_redirect_pc", redirect_pc);
        next_cycle();
        idle();
        sample();
        lookup("bne_next", 32'h200, 1'b1, 32'h500);
        expect_v(32'd4);
        check("bne_mispred", mispred_cnt);

        // Four taken BEQs at 0x300: miss -> 10, then 11, saturate
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (i == 0) drive(1, 1, 0, 3'b000, 32'h300, 32'h700, 0, 32'h0, 0, 1);
            else        drive(1, 1, 0, 3'b000, 32'h300, 32'h700, 1, 32'h700, 0, 1);
            sample();
            expect_v((i == 0) ? 32'd1 : 32'd0);
            check("beq_t_redirect", {31'd0, redirect});
        end
        next_cycle();
        idle();
        sample();
        lookup("beq_sat", 32'h300, 1'b1, 32'h700);
        expect_v(32'd5);
        check("beq_mispred", mispred_cnt);

        // Two not-taken BEQs: 11 -> 10 (still taken) -> 01 (not taken)
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            drive(1, 1, 0, 3'b000, 32'h300, 32'h700, 1, 32'h700, 0, 0);
            sample();
            expect_v(32'h304);
            check("beq_nt_redirect_pc", redirect_pc);
            next_cycle();
            idle();
            sample();
            lookup("beq_nt", 32'h300, (i == 0), 32'h700);
        end
        expect_v(32'd7);
        check("beq_nt_mispred", mispred_cnt);

        // Aliasing: 0x144 and 0x104 share index 1 with different tags
        next_cycle();
        drive(1, 0, 1, 3'b000, 32'h144, 32'h900, 1, 32'h900, 0, 0);
        sample();
        expect_v(32'd0);
        check("alias_jal_redirect", {31'd0, redirect});
        next_cycle();
        idle();
        sample();
        lookup("alias_144", 32'h144, 1'b1, 32'h900);
        next_cycle();
        drive(1, 1, 0, 3'b101, 32'h104, 32'hA00, 1, 32'hA00, 0, 0);  // BGE taken
        sample();
        expect_v(32'd1); expect_v(32'd0);
        check("alias_bge_taken", {31'd0, ex_taken});
        check("alias_bge_redirect", {31'd0, redirect});
        next_cycle();
        idle();
        sample();
        lookup("alias_104", 32'h104, 1'b1, 32'hA00);
        lookup("alias_144_rej", 32'h144, 1'b0, 32'hA00);

        // Not-taken BLT with a foreign tag on index 1 leaves the entry alone
        next_cycle();
        drive(1, 1, 0, 3'b100, 32'h184, 32'hB00, 0, 32'h0, 0, 0);
        sample();
        expect_v(32'd0); expect_v(32'd0);
        check("blt_nt_taken", {31'd0, ex_taken});
        check("blt_nt_redirect", {31'd0, redirect});
        next_cycle();
        idle();
        sample();
        lookup("blt_nt_keep", 32'h104, 1'b1, 32'hA00);

        // Illegal funct3=010 on the owning PC: no redirect, no training
        next_cycle();
        drive(1, 1, 0, 3'b010, 32'h104, 32'hC00, 0, 32'h0, 1, 1);
        sample();
        expect_v(32'd1); expect_v(32'd0); expect_v(32'd0);
        check("ill_unsigned", {31'd0, br_unsigned});
        check("ill_taken", {31'd0, ex_taken});
        check("ill_redirect", {31'd0, redirect});
        next_cycle();
        idle();
        sample();
        lookup("ill_keep", 32'h104, 1'b1, 32'hA00);
        expect_v(32'd7);
        check("ill_mispred", mispred_cnt);

        // Non-branch with valid=1
        next_cycle();
        drive(1, 0, 0, 3'b000, 32'h104, 32'hD00, 1, 32'hD00, 1, 1);
        sample();
        expect_v(32'd0); expect_v(32'd0);
        check("nonbr_taken", {31'd0, ex_taken});
        check("nonbr_redirect", {31'd0, redirect});
        next_cycle();
        idle();
        sample();
        lookup("nonbr_keep", 32'h104, 1'b1, 32'hA00);

        // Bubble carrying a taken jump
        next_cycle();
        drive(0, 0, 1, 3'b000, 32'h104, 32'hE00, 0, 32'h0, 0, 0);
        sample();
        expect_v(32'd0); expect_v(32'd0);
        check("bubble_taken", {31'd0, ex_taken});
        check("bubble_redirect", {31'd0, redirect});
        next_cycle();
        idle();
        sample();
        lookup("bubble_keep", 32'h104, 1'b1, 32'hA00);
        expect_v(32'd7);
        check("bubble_mispred", mispred_cnt);

        // Asynchronous reset in the middle of a training cycle
        next_cycle();
        f_pc = 32'h104;
        drive(1, 0, 1, 3'b000, 32'h104, 32'hF00, 0, 32'h0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_v(32'd0); expect_v(32'd0); expect_v(32'd0); expect_v(32'd1);
        check("arst_pred_taken", {31'd0, pred_taken});
        check("arst_pred_target", pred_target);
        check("arst_mispred", mispred_cnt);
        check("arst_ex_taken", {31'd0, ex_taken});
        next_cycle();
        idle();
        rst_n = 1'b1;
        sample();
        lookup("arst_after", 32'h104, 1'b0, 32'h0);
        expect_v(32'd0);
        check("arst_after_mispred", mispred_cnt);

        // First update after deassertion is applied
        next_cycle();
        drive(1, 0, 1, 3'b000, 32'h100, 32'h44, 0, 32'h0, 0, 0);
        sample();
        next_cycle();
        idle();
        sample();
        lookup("post_rst", 32'h100, 1'b1, 32'h44);
        expect_v(32'd1);
        check("post_rst_mispred", mispred_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
